// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode/writeback bus for the scoreboarded register file
interface reg_file_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              writeReg;
    logic [ADDR_W-1:0] write_reg_num;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg_num_1;
    logic [ADDR_W-1:0] read_reg_num_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              read_ready_1;
    logic              read_ready_2;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_reg_num;
    logic              reserve_stall;
    logic              pending_any;

    modport master (
        output writeReg, write_reg_num, write_data,
        output read_reg_num_1, read_reg_num_2,
        output reserve_en, reserve_reg_num,
        input  read_data_1, read_data_2, read_ready_1, read_ready_2,
        input  reserve_stall, pending_any
    );

    modport slave (
        input  writeReg, write_reg_num, write_data,
        input  read_reg_num_1, read_reg_num_2,
        input  reserve_en, reserve_reg_num,
        output read_data_1, read_data_2, read_ready_1, read_ready_2,
        output reserve_stall, pending_any
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - DEPTH x DATA_W register file, 2R/1W, with pending scoreboard
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    reg_file_sb_if.slave      bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_ON = (ZERO_REG != 0);
    localparam bit BYP_ON  = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;

    logic              w_wr_en;
    logic              w_rsv_zero;
    logic              w_rsv_freed;
    logic              w_rsv_stall;
    logic              w_rsv_set;
    logic [DEPTH-1:0]  w_pending_next;

    logic [ADDR_W-1:0] w_rd_addr  [2];
    logic [DATA_W-1:0] w_rd_data  [2];
    logic              w_rd_ready [2];
    logic              w_rd_byp   [2];
    logic              w_rd_zero  [2];

    // Writes to the hardwired zero register are dropped entirely, so pending[0] never sets.
    assign w_wr_en     = bus.writeReg && !(ZERO_ON && (bus.write_reg_num == '0));
    assign w_rsv_zero  = ZERO_ON && (bus.reserve_reg_num == '0);
    assign w_rsv_freed = bus.writeReg && (bus.write_reg_num == bus.reserve_reg_num);
    assign w_rsv_stall = bus.reserve_en && !w_rsv_zero
                         && r_pending[bus.reserve_reg_num] && !w_rsv_freed;
    assign w_rsv_set   = bus.reserve_en && !w_rsv_zero && !w_rsv_stall;

    // Set after clear: a same-edge re-reservation leaves the new producer pending.
    always_comb begin
        w_pending_next = r_pending;
        if (w_wr_en) begin
            w_pending_next[bus.write_reg_num] = 1'b0;
        end
        if (w_rsv_set) begin
            w_pending_next[bus.reserve_reg_num] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
            r_pending <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[bus.write_reg_num] <= bus.write_data;
            end
            r_pending <= w_pending_next;
        end
    end

    assign w_rd_addr[0] = bus.read_reg_num_1;
    assign w_rd_addr[1] = bus.read_reg_num_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_zero[p] = ZERO_ON && (w_rd_addr[p] == '0);
            w_rd_byp[p]  = BYP_ON && w_wr_en && (bus.write_reg_num == w_rd_addr[p]);
            w_rd_data[p] = w_rd_byp[p] ? bus.write_data : r_regs[w_rd_addr[p]];
            if (w_rd_zero[p]) begin
                w_rd_data[p] = '0;
            end
            w_rd_ready[p] = w_rd_zero[p] || w_rd_byp[p] || !r_pending[w_rd_addr[p]];
        end
    end

    assign bus.read_data_1   = w_rd_data[0];
    assign bus.read_data_2   = w_rd_data[1];
    assign bus.read_ready_1  = w_rd_ready[0];
    assign bus.read_ready_2  = w_rd_ready[1];
    assign bus.reserve_stall = w_rsv_stall;
    assign bus.pending_any   = |r_pending;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed bench for reg_file_sb across three parameter sets
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // b0: defaults; b1: zero register, no bypass; b2: 16-bit x 16
    reg_file_sb_if #(.DATA_W(8),  .ADDR_W(3)) b0 ();
    reg_file_sb_if #(.DATA_W(8),  .ADDR_W(3)) b1 ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) b2 ();

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .bus(b0));
    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1));
    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.writeReg = 1'b0; b0.reserve_en = 1'b0;
        b1.writeReg = 1'b0; b1.reserve_en = 1'b0;
        b2.writeReg = 1'b0; b2.reserve_en = 1'b0;
    endtask

    task automatic init_bus();
        b0.write_reg_num = '0; b0.write_data = '0; b0.read_reg_num_1 = '0;
        b0.read_reg_num_2 = '0; b0.reserve_reg_num = '0;
        b1.write_reg_num = '0; b1.write_data = '0; b1.read_reg_num_1 = '0;
        b1.read_reg_num_2 = '0; b1.reserve_reg_num = '0;
        b2.write_reg_num = '0; b2.write_data = '0; b2.read_reg_num_1 = '0;
        b2.read_reg_num_2 = '0; b2.reserve_reg_num = '0;
        idle();
    endtask

    task automatic test_reset();
        logic [7:0] e1, e2;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            b0.read_reg_num_1 = 3'(a);
            b0.read_reg_num_2 = 3'(7 - a);
            b1.read_reg_num_1 = 3'(a);
            #1;
            e1 = 8'(a);
            e2 = 8'(7 - a);
            total++;
            if (b0.read_data_1 !== e1) begin
                bad++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", a, b0.read_data_1, e1);
            end
            total++;
            if (b0.read_data_2 !== e2) begin
                bad++; $display("FAIL reset_rd2[%0d] got=%h exp=%h", a, b0.read_data_2, e2);
            end
            total++;
            if ({b0.read_ready_1, b0.read_ready_2} !== 2'b11) begin
                bad++; $display("FAIL reset_ready[%0d] got=%b%b exp=11", a, b0.read_ready_1, b0.read_ready_2);
            end
            e1 = (a == 0) ? 8'h00 : 8'(a);
            total++;
            if (b1.read_data_1 !== e1) begin
                bad++; $display("FAIL reset_zero_rd1[%0d] got=%h exp=%h", a, b1.read_data_1, e1);
            end
        end
        total++;
        if (b0.pending_any !== 1'b0 || b0.reserve_stall !== 1'b0) begin
            bad++; $display("FAIL reset_pend got=%b stall=%b exp=0 0", b0.pending_any, b0.reserve_stall);
        end
    endtask

    task automatic test_bypass();
        b0.writeReg = 1'b1; b0.write_reg_num = 3'd5; b0.write_data = 8'hA5;
        b0.read_reg_num_1 = 3'd5;
        b1.writeReg = 1'b1; b1.write_reg_num = 3'd5; b1.write_data = 8'hA5;
        b1.read_reg_num_1 = 3'd5;
        #1;
        total++;
        if (b0.read_data_1 !== 8'hA5) begin
            bad++; $display("FAIL bypass_same got=%h exp=a5", b0.read_data_1);
        end
        total++;
        if (b1.read_data_1 !== 8'h05) begin
            bad++; $display("FAIL nobypass_same got=%h exp=05", b1.read_data_1);
        end
        tick();
        idle();
        #1;
        total++;
        if (b0.read_data_1 !== 8'hA5) begin
            bad++; $display("FAIL bypass_next got=%h exp=a5", b0.read_data_1);
        end
        total++;
        if (b1.read_data_1 !== 8'hA5) begin
            bad++; $display("FAIL nobypass_next got=%h exp=a5", b1.read_data_1);
        end
    endtask

    task automatic test_reserve();
        b0.reserve_en = 1'b1; b0.reserve_reg_num = 3'd3; b0.read_reg_num_2 = 3'd3;
        #1;
        total++;
        if (b0.reserve_stall !== 1'b0 || b0.read_ready_2 !== 1'b1) begin
            bad++; $display("FAIL rsv_first got stall=%b rdy=%b exp=0 1", b0.reserve_stall, b0.read_ready_2);
        end
        tick();
        b0.reserve_en = 1'b0;
        #1;
        total++;
        if (b0.read_ready_2 !== 1'b0 || b0.pending_any !== 1'b1) begin
            bad++; $display("FAIL rsv_pending got rdy=%b pend=%b exp=0 1", b0.read_ready_2, b0.pending_any);
        end
        b0.reserve_en = 1'b1;
        #1;
        total++;
        if (b0.reserve_stall !== 1'b1) begin
            bad++; $display("FAIL rsv_again got stall=%b exp=1", b0.reserve_stall);
        end
        tick();
        b0.reserve_en = 1'b0;
        b0.writeReg = 1'b1; b0.write_reg_num = 3'd3; b0.write_data = 8'h3C;
        #1;
        total++;
        if (b0.read_ready_2 !== 1'b1 || b0.read_data_2 !== 8'h3C) begin
            bad++; $display("FAIL wb_bypass got rdy=%b data=%h exp=1 3c", b0.read_ready_2, b0.read_data_2);
        end
        tick();
        idle();
        #1;
        total++;
        if (b0.read_ready_2 !== 1'b1 || b0.read_data_2 !== 8'h3C || b0.pending_any !== 1'b0) begin
            bad++; $display("FAIL wb_done got rdy=%b data=%h pend=%b exp=1 3c 0",
                            b0.read_ready_2, b0.read_data_2, b0.pending_any);
        end
    endtask

    task automatic test_back_to_back();
        b0.reserve_en = 1'b1; b0.reserve_reg_num = 3'd3;
        tick();
        b0.writeReg = 1'b1; b0.write_reg_num = 3'd3; b0.write_data = 8'h7E;
        #1;
        total++;
        if (b0.reserve_stall !== 1'b0) begin
            bad++; $display("FAIL wr_rsv_stall got=%b exp=0", b0.reserve_stall);
        end
        tick();
        idle();
        #1;
        total++;
        if (b0.read_data_2 !== 8'h7E || b0.read_ready_2 !== 1'b0 || b0.pending_any !== 1'b1) begin
            bad++; $display("FAIL wr_rsv_after got data=%h rdy=%b pend=%b exp=7e 0 1",
                            b0.read_data_2, b0.read_ready_2, b0.pending_any);
        end
        b0.writeReg = 1'b1; b0.write_data = 8'h3C;
        tick();
        idle();
        #1;
        total++;
        if (b0.pending_any !== 1'b0 || b0.read_data_2 !== 8'h3C) begin
            bad++; $display("FAIL wr_rsv_clear got pend=%b data=%h exp=0 3c", b0.pending_any, b0.read_data_2);
        end
    endtask

    task automatic test_zero_reg();
        b1.reserve_en = 1'b1; b1.reserve_reg_num = 3'd2;
        tick();
        b1.reserve_en = 1'b1; b1.reserve_reg_num = 3'd0;
        b1.writeReg = 1'b1; b1.write_reg_num = 3'd0; b1.write_data = 8'hFF;
        b1.read_reg_num_1 = 3'd0; b1.read_reg_num_2 = 3'd0;
        #1;
        total++;
        if (b1.read_data_1 !== 8'h00 || b1.read_ready_1 !== 1'b1 || b1.reserve_stall !== 1'b0) begin
            bad++; $display("FAIL zero_same got data=%h rdy=%b stall=%b exp=00 1 0",
                            b1.read_data_1, b1.read_ready_1, b1.reserve_stall);
        end
        tick();
        idle();
        #1;
        total++;
        if (b1.read_data_2 !== 8'h00 || b1.read_ready_2 !== 1'b1 || b1.pending_any !== 1'b1) begin
            bad++; $display("FAIL zero_after got data=%h rdy=%b pend=%b exp=00 1 1",
                            b1.read_data_2, b1.read_ready_2, b1.pending_any);
        end
        b1.writeReg = 1'b1; b1.write_reg_num = 3'd2; b1.write_data = 8'h22;
        b1.read_reg_num_1 = 3'd2;
        #1;
        total++;
        if (b1.read_ready_1 !== 1'b0 || b1.read_data_1 !== 8'h02) begin
            bad++; $display("FAIL nobypass_ready got rdy=%b data=%h exp=0 02", b1.read_ready_1, b1.read_data_1);
        end
        tick();
        idle();
        #1;
        total++;
        if (b1.read_ready_1 !== 1'b1 || b1.read_data_1 !== 8'h22 || b1.pending_any !== 1'b0) begin
            bad++; $display("FAIL zero_wb got rdy=%b data=%h pend=%b exp=1 22 0",
                            b1.read_ready_1, b1.read_data_1, b1.pending_any);
        end
    endtask

    task automatic test_wide_reset();
        b2.writeReg = 1'b1; b2.write_reg_num = 4'd9; b2.write_data = 16'hBEEF;
        tick();
        idle();
        b2.reserve_en = 1'b1; b2.reserve_reg_num = 4'd9;
        b2.read_reg_num_1 = 4'd9; b2.read_reg_num_2 = 4'd15;
        tick();
        idle();
        #1;
        total++;
        if (b2.read_data_1 !== 16'hBEEF || b2.read_ready_1 !== 1'b0 || b2.pending_any !== 1'b1) begin
            bad++; $display("FAIL wide_pre got data=%h rdy=%b pend=%b exp=beef 0 1",
                            b2.read_data_1, b2.read_ready_1, b2.pending_any);
        end
        rst = 1'b0;
        b2.writeReg = 1'b1; b2.write_reg_num = 4'd9; b2.write_data = 16'h1234;
        b2.reserve_en = 1'b1; b2.reserve_reg_num = 4'd15;
        tick();
        rst = 1'b1;
        idle();
        #1;
        total++;
        if (b2.read_data_1 !== 16'd9 || b2.read_ready_1 !== 1'b1 || b2.pending_any !== 1'b0) begin
            bad++; $display("FAIL wide_reset got data=%h rdy=%b pend=%b exp=0009 1 0",
                            b2.read_data_1, b2.read_ready_1, b2.pending_any);
        end
        total++;
        if (b2.read_data_2 !== 16'd15 || b2.read_ready_2 !== 1'b1) begin
            bad++; $display("FAIL wide_reg15 got data=%h rdy=%b exp=000f 1", b2.read_data_2, b2.read_ready_2);
        end
    endtask

    initial begin
        init_bus();
        test_reset();
        test_bypass();
        test_reserve();
        test_back_to_back();
        test_zero_reg();
        test_wide_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
